// File: rtl/eth_mdio_responder_if.sv
// -----------------------------------------------------------------------------
// eth_mdio_responder_if
// Register-file side bus of the MDIO responder.
//   RegAddr    register address of the current/last frame
//   RegRd      one-Clk read strobe
//   RegRdData  read data, valid the Clk after RegRd
//   RegWr      one-Clk write strobe
//   RegWrData  write data, valid with RegWr
// master = responder (issues strobes), slave = register file.
// -----------------------------------------------------------------------------
interface eth_mdio_responder_if;
   logic [4:0]  RegAddr;
   logic        RegRd;
   logic [15:0] RegRdData;
   logic        RegWr;
   logic [15:0] RegWrData;

   modport master (output RegAddr, RegRd, RegWr, RegWrData, input RegRdData);
   modport slave  (input RegAddr, RegRd, RegWr, RegWrData, output RegRdData);
endinterface

// File: rtl/eth_mdio_responder.sv
// -----------------------------------------------------------------------------
// eth_mdio_responder
// PHY-side Clause 22 MII management responder. Mdc/MdiI are oversampled in the
// Clk domain, management frames are decoded, and single-Clk read/write strobes
// are issued to a local register file. Read data is returned on Mdo/MdoEn.
//
// Ports:
//   Clk, Reset   host clock, synchronous active-high reset
//   Mdc, MdiI    management clock/data from the master (asynchronous to Clk)
//   PhyAddr      strapped PHY address (static)
//   Mdo, MdoEn   management data out and its output enable
//   Busy         high from ST accepted until frame end
//   regBus       register-file bus (RegAddr/RegRd/RegRdData/RegWr/RegWrData)
// Parameters:
//   PRE_MIN      preamble ones required before ST (0 = none)
//   BCAST_EN     PHY address 0 also matches write frames
// -----------------------------------------------------------------------------
module eth_mdio_responder #(
   parameter int PRE_MIN  = 32,
   parameter bit BCAST_EN = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Mdc,
   input  logic       MdiI,
   input  logic [4:0] PhyAddr,
   output logic       Mdo,
   output logic       MdoEn,
   output logic       Busy,
   eth_mdio_responder_if.master regBus
);

   // The preamble counter saturates at 32, so larger thresholds clamp to 32.
   localparam int         PRE_SAT    = (PRE_MIN > 32) ? 32 : PRE_MIN;
   localparam logic [5:0] PRE_THRESH = PRE_SAT[5:0];

   typedef enum logic [3:0] {
      IDLE, ST2, OP, PHYAD, REGAD, RDDATA, WRTA, WRDATA, SKIP
   } state_t;

   state_t      state, stateNext;
   logic        mdc_p0, mdc_p1, mdc_p2;
   logic        mdi_p0, mdi_p1;
   logic        mdcRise, bitIn;
   logic [4:0]  bitIdx, kNow;
   logic [5:0]  preCnt;
   logic [1:0]  opBits, opNext;
   logic        isWrite;
   logic [4:0]  addrShift, addrNext;
   logic [15:0] wrShift;
   logic [15:0] rdShift;
   logic        capPend;
   logic        startFrame, endFrame, doRd, doWr, loadAddr;

   // Stage p1 -> p2: rising edge of the synchronized Mdc; data sampled with it.
   assign mdcRise  = mdc_p1 & ~mdc_p2;
   assign bitIn    = mdi_p1;
   // bitIdx holds the index of the last sampled frame bit; kNow is this edge's.
   assign kNow     = bitIdx + 5'd1;
   assign opNext   = {opBits[0], bitIn};
   assign addrNext = {addrShift[3:0], bitIn};
   assign isWrite  = (opBits == 2'b01);

   always_comb begin
      stateNext  = state;
      startFrame = 1'b0;
      endFrame   = 1'b0;
      doRd       = 1'b0;
      doWr       = 1'b0;
      loadAddr   = 1'b0;
      if (mdcRise) begin
         unique case (state)
            IDLE: begin
               if (!bitIn && (preCnt >= PRE_THRESH)) begin
                  stateNext  = ST2;
                  startFrame = 1'b1;
               end
            end
            ST2: begin
               if (bitIn) begin
                  stateNext = OP;
               end else begin
                  stateNext = IDLE;
                  endFrame  = 1'b1;
               end
            end
            OP: begin
               if (kNow == 5'd3)
                  stateNext = (opNext == 2'b10 || opNext == 2'b01) ? PHYAD : SKIP;
            end
            PHYAD: begin
               // Broadcast address is honoured for writes only.
               if (kNow == 5'd8)
                  stateNext = ((addrNext == PhyAddr) ||
                               (BCAST_EN && (addrNext == 5'd0) && isWrite)) ? REGAD : SKIP;
            end
            REGAD: begin
               if (kNow == 5'd13) begin
                  loadAddr = 1'b1;
                  if (isWrite) begin
                     stateNext = WRTA;
                  end else begin
                     stateNext = RDDATA;
                     doRd      = 1'b1;
                  end
               end
            end
            RDDATA: begin
               if (kNow == 5'd31) begin
                  stateNext = IDLE;
                  endFrame  = 1'b1;
               end
            end
            WRTA: begin
               if (kNow == 5'd15) stateNext = WRDATA;
            end
            WRDATA: begin
               if (kNow == 5'd31) begin
                  stateNext = IDLE;
                  endFrame  = 1'b1;
                  doWr      = 1'b1;
               end
            end
            SKIP: begin
               if (kNow == 5'd31) begin
                  stateNext = IDLE;
                  endFrame  = 1'b1;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         mdc_p0           <= 1'b0;
         mdc_p1           <= 1'b0;
         mdc_p2           <= 1'b0;
         mdi_p0           <= 1'b0;
         mdi_p1           <= 1'b0;
         state            <= IDLE;
         bitIdx           <= 5'd0;
         preCnt           <= 6'd0;
         opBits           <= 2'b00;
         capPend          <= 1'b0;
         Busy             <= 1'b0;
         Mdo              <= 1'b0;
         MdoEn            <= 1'b0;
         regBus.RegAddr   <= 5'd0;
         regBus.RegRd     <= 1'b0;
         regBus.RegWr     <= 1'b0;
         regBus.RegWrData <= 16'd0;
      end else begin
         // Stage p0 -> p1: two-flop synchronizers; p2 keeps last Mdc for edge detect.
         mdc_p0 <= Mdc;
         mdc_p1 <= mdc_p0;
         mdc_p2 <= mdc_p1;
         mdi_p0 <= MdiI;
         mdi_p1 <= mdi_p0;

         state        <= stateNext;
         regBus.RegRd <= doRd;
         regBus.RegWr <= doWr;
         // The register file answers the Clk after RegRd; capture one Clk later.
         capPend      <= regBus.RegRd;

         if (startFrame)
            bitIdx <= 5'd0;
         else if (mdcRise && state != IDLE)
            bitIdx <= kNow;

         if (startFrame || endFrame)
            preCnt <= 6'd0;
         else if (mdcRise && state == IDLE) begin
            if (!bitIn)
               preCnt <= 6'd0;
            else if (preCnt != 6'd32)
               preCnt <= preCnt + 6'd1;
         end

         if (startFrame)
            Busy <= 1'b1;
         else if (endFrame)
            Busy <= 1'b0;

         if (mdcRise && state == OP)
            opBits <= opNext;

         if (loadAddr)
            regBus.RegAddr <= addrNext;

         if (doWr)
            regBus.RegWrData <= {wrShift[14:0], bitIn};

         // Edge 14 drives the low TA bit, edges 15..30 drive data, edge 31 releases.
         if (mdcRise && state == RDDATA) begin
            if (kNow == 5'd14) begin
               MdoEn <= 1'b1;
               Mdo   <= 1'b0;
            end else if (kNow == 5'd31) begin
               MdoEn <= 1'b0;
               Mdo   <= 1'b0;
            end else begin
               Mdo   <= rdShift[15];
            end
         end
      end
   end

   // Shift registers carry data only and need no reset.
   always_ff @(posedge Clk) begin
      if (mdcRise && (state == PHYAD || state == REGAD))
         addrShift <= addrNext;
      if (mdcRise && state == WRDATA)
         wrShift <= {wrShift[14:0], bitIn};
      if (capPend)
         rdShift <= regBus.RegRdData;
      else if (mdcRise && state == RDDATA && kNow != 5'd14 && kNow != 5'd31)
         rdShift <= {rdShift[14:0], 1'b0};
   end

endmodule
